// File: rtl/labyrinth_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : labyrinth_pkg
//  Description : Shared constants and types for the labyrinth game logic:
//                map geometry, pixel codes, map port widths and the read
//                tag carried alongside each outstanding map read.
//  Revision    : 1.0 - initial release
// ============================================================================
package labyrinth_pkg;

   // Pixel codes
   localparam logic [7:0] VALID_MOVE_PX = 8'h26;
   localparam logic [7:0] OOB_PX        = 8'h00;

   // Map geometry (exclusive upper bounds)
   localparam int MAP_COLS = 640;
   localparam int MAP_ROWS = 480;

   // Map port widths
   localparam int MAP_COL_W = 10;
   localparam int MAP_ROW_W = 10;
   localparam int MAP_PX_W  = 8;

   // Largest supported requester count; sizes the tag id field
   localparam int MAP_MAX_REQ = 4;

   // Tag that travels with each read slot through the latency pipeline
   typedef struct packed {
      logic                   valid;
      logic [MAP_MAX_REQ-1:0] id;    // one-hot originating requester
      logic                   oob;   // address outside the map
   } map_tag_t;

   // True when a column/row pair lies outside the given map bounds
   function automatic logic addr_oob(input logic [MAP_COL_W-1:0] col,
                                     input logic [MAP_ROW_W-1:0] row,
                                     input int                   cols,
                                     input int                   rows);
      return (int'(col) >= cols) || (int'(row) >= rows);
   endfunction

endpackage
`default_nettype wire

// File: rtl/map_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : map_read_arbiter_if
//  Description : Bundles the requester handshake, the map port A address/data
//                and the shared read-return bus of the map read arbiter.
//                slave  : the arbiter itself.
//                master : the environment (requesters plus map instance).
//  Revision    : 1.0 - initial release
// ============================================================================
interface map_read_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import labyrinth_pkg::*;

   // Requester side
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*MAP_COL_W-1:0] req_col;
   logic [NUM_REQ*MAP_ROW_W-1:0] req_row;
   logic [NUM_REQ-1:0]           gnt;

   // Map port A
   logic [MAP_COL_W-1:0]         map_col_addr;
   logic [MAP_ROW_W-1:0]         map_row_addr;
   logic [MAP_PX_W-1:0]          map_data;

   // Read return
   logic [NUM_REQ-1:0]           rd_valid;
   logic [MAP_PX_W-1:0]          rd_data;

   modport slave (
      input  req, req_col, req_row, map_data,
      output gnt, map_col_addr, map_row_addr, rd_valid, rd_data
   );

   modport master (
      output req, req_col, req_row, map_data,
      input  gnt, map_col_addr, map_row_addr, rd_valid, rd_data
   );

endinterface
`default_nettype wire

// File: rtl/map_read_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Starting one past the
//                last winner and wrapping modulo NUM_REQ, the first asserted
//                request wins. Produces a one-hot grant, the encoded winner
//                and an any-grant flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 2
) (
   input  wire logic [NUM_REQ-1:0] i_req,
   input  wire logic [IDX_W-1:0]   i_last,
   output logic      [NUM_REQ-1:0] o_gnt,
   output logic      [IDX_W-1:0]   o_winner,
   output logic                    o_any
);

   // Walk last+1 .. last+NUM_REQ and lock onto the first live request
   always_comb begin : p_search
      int idx;
      o_gnt    = '0;
      o_winner = i_last;
      o_any    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(i_last) + k) % NUM_REQ;
         if (!o_any && i_req[idx]) begin
            o_gnt[idx] = 1'b1;
            o_winner   = IDX_W'(idx);
            o_any      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/map_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : map_read_arbiter
//  Description : Shares the map's collision read port (port A) between up to
//                four requesters. Round-robin arbitration accepts at most one
//                read per cycle; each accepted read is tracked by a tag that
//                walks a MAP_LATENCY+1 deep pipeline so the pixel can be
//                routed back to its requester with a one-cycle valid pulse.
//                Out-of-range reads skip the map value and return OOB_PX with
//                the same latency as a normal read.
//  Revision    : 1.0 - initial release
// ============================================================================
module map_read_arbiter #(
   parameter int         NUM_REQ     = 2,                      // 2..4
   parameter int         MAP_LATENCY = 2,
   parameter int         MAP_COLS    = labyrinth_pkg::MAP_COLS,
   parameter int         MAP_ROWS    = labyrinth_pkg::MAP_ROWS,
   parameter logic [7:0] OOB_PX      = labyrinth_pkg::OOB_PX
) (
   input wire logic          clk,
   input wire logic          reset,   // asynchronous, active low
   map_read_arbiter_if.slave bus
);
   import labyrinth_pkg::*;

   // Requester index width; NUM_REQ never exceeds four
   localparam int c_IDX_W      = 2;
   // Tag slots between the issue edge and the return edge
   localparam int c_PIPE_DEPTH = MAP_LATENCY + 1;
   // Pointer reset value gives requester 0 the first turn
   localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);

   // ------------------------------------------------------------------------
   //  Signals
   // ------------------------------------------------------------------------
   logic [NUM_REQ-1:0]     w_arb_gnt;
   logic [c_IDX_W-1:0]     w_arb_winner;
   logic                   w_arb_any;
   logic [NUM_REQ-1:0]     w_gnt;
   logic                   w_issue;
   logic [MAP_COL_W-1:0]   w_sel_col;
   logic [MAP_ROW_W-1:0]   w_sel_row;
   logic [MAP_MAX_REQ-1:0] w_new_id;
   map_tag_t               w_new_tag;
   map_tag_t               w_ret_tag;

   logic [c_IDX_W-1:0]     r_last;
   logic [MAP_COL_W-1:0]   r_col_addr;
   logic [MAP_ROW_W-1:0]   r_row_addr;
   map_tag_t               r_tag [c_PIPE_DEPTH];
   logic [NUM_REQ-1:0]     r_rd_valid;
   logic [MAP_PX_W-1:0]    r_rd_data;

   // ------------------------------------------------------------------------
   //  Arbitration
   // ------------------------------------------------------------------------
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_rr_arbiter (
      .i_req    (bus.req),
      .i_last   (r_last),
      .o_gnt    (w_arb_gnt),
      .o_winner (w_arb_winner),
      .o_any    (w_arb_any)
   );

   // Nothing is accepted while reset is held, so gnt must read 0 then too
   assign w_issue = reset & w_arb_any;
   assign w_gnt   = reset ? w_arb_gnt : '0;

   // Winner's address, picked out of the packed request buses
   assign w_sel_col = bus.req_col[int'(w_arb_winner)*MAP_COL_W +: MAP_COL_W];
   assign w_sel_row = bus.req_row[int'(w_arb_winner)*MAP_ROW_W +: MAP_ROW_W];

   // Build the tag for this cycle's slot (all zero when nothing was granted)
   always_comb begin
      w_new_id                = '0;
      w_new_id[NUM_REQ-1:0]   = w_gnt;
      w_new_tag.valid         = w_issue;
      w_new_tag.id            = w_new_id;
      w_new_tag.oob           = w_issue &
                                addr_oob(w_sel_col, w_sel_row, MAP_COLS, MAP_ROWS);
   end

   // Round-robin pointer follows the most recent winner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= c_LAST_RST;
      end else if (w_issue) begin
         r_last <= w_arb_winner;
      end
   end

   // ------------------------------------------------------------------------
   //  Issue: map address registers hold between grants
   // ------------------------------------------------------------------------
   // Load the winner's address onto map port A on each grant edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col_addr <= '0;
         r_row_addr <= '0;
      end else if (w_issue) begin
         r_col_addr <= w_sel_col;
         r_row_addr <= w_sel_row;
      end
   end

   // Tag shift pipeline; an idle cycle pushes an invalid tag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < c_PIPE_DEPTH; s++) begin
            r_tag[s] <= '0;
         end
      end else begin
         r_tag[0] <= w_new_tag;
         for (int s = 1; s < c_PIPE_DEPTH; s++) begin
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   //  Return: the tag leaving the pipeline lines up with its map_data
   // ------------------------------------------------------------------------
   assign w_ret_tag = r_tag[c_PIPE_DEPTH-1];

   // Capture the pixel (or the out-of-range code) and pulse the owner's valid
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_valid <= '0;
         r_rd_data  <= '0;
      end else if (w_ret_tag.valid) begin
         r_rd_valid <= w_ret_tag.id[NUM_REQ-1:0];
         r_rd_data  <= w_ret_tag.oob ? OOB_PX : bus.map_data;
      end else begin
         r_rd_valid <= '0;
      end
   end

   // ------------------------------------------------------------------------
   //  Outputs
   // ------------------------------------------------------------------------
   assign bus.gnt          = w_gnt;
   assign bus.map_col_addr = r_col_addr;
   assign bus.map_row_addr = r_row_addr;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.rd_data      = r_rd_data;

endmodule
`default_nettype wire
